// File: rtl/instruction_fetch.sv
// Instruction fetch: fetch PC plus a DEPTH-entry {pc, instr} buffer feeding decode.
// Optional FETCH_STATS_EN adds a popped-instruction counter on port fetch_count.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
`endif
  output logic [31:0] out_pc
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

  logic [31:0]             r_fpc;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW:0]             r_count;
  logic [DEPTH-1:0][31:0]  r_pc_q;
  logic [DEPTH-1:0][31:0]  r_ins_q;

  logic        w_pop;
  logic        w_push;
  logic [31:0] w_tgt;

  assign imem_addr = r_fpc;
  assign out_valid = (r_count != '0);
  assign out_pc    = r_pc_q[r_rd_ptr];
  assign out_instr = r_ins_q[r_rd_ptr];

  // Redirect masks both sides; a pop on a redirect edge is lost with the flush.
  assign w_pop  = out_valid && out_ready && !redirect_valid;
  assign w_push = !redirect_valid && ((r_count != CNT_FULL) || (out_valid && out_ready));
  assign w_tgt  = redirect_pc & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc    <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_fpc    <= w_tgt;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fpc    <= r_fpc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: it is only visible while count says it is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]  <= r_fpc;
      r_ins_q[r_wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_fetch_count <= '0;
    else if (w_pop)
      r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
